mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Memory-access stage of the 5-stage MIPS pipeline; sits directly downstream of the execute stage and consumes the EX/MEM pipeline register outputs.
- Resolves branches, performs data-memory loads and stores with configurable multi-cycle latency, and registers results into the MEM/WB pipeline register for write-back.
- Raises a stall while a multi-cycle access is in flight; the upstream stages must hold while it is high.

Parameters:
- ADDR_W, 8, word-address width; data memory holds 2**ADDR_W 32-bit words.
- MEM_LAT, 2, cycles per load/store access; legal range 1..15.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- wb  in  2  write-back control from EX/MEM; passed through to MEM/WB.
- mem  in  3  memory control: [2]=branch, [1]=memread, [0]=memwrite.
- br_dst  in  32  branch target from EX/MEM.
- z_flag  in  1  ALU zero flag from EX/MEM.
- alu_out  in  32  ALU result; byte address for loads and stores.
- rt  in  32  store data.
- wr_dst  in  5  destination register number.
- pc_src  out  1  branch taken = mem[2] & z_flag; combinational.
- br_addr  out  32  equals br_dst; combinational.
- stall  out  1  access in progress; upstream must hold EX/MEM and earlier.
- wb_wb  out  2  registered wb.
- rd_data_wb  out  32  registered load data.
- alu_out_wb  out  32  registered alu_out.
- wr_dst_wb  out  5  registered wr_dst.
- align_err  out  1  sticky misalignment flag; see Optional Feature.

Behaviour:
- Reset is asynchronous and active-high. All MEM/WB outputs, align_err, the latency counter and the state are cleared to 0 immediately on rst. stall is 0 while rst is high. Data-memory contents are not reset; they are zero at time 0 in simulation.
- Word index is alu_out[ADDR_W+1:2]. Address bits above this field are ignored, so out-of-range addresses wrap.
- An access is in progress whenever mem[1] | mem[0] is set.
- If mem[1] and mem[0] are both set, the access is treated as a store, and rd_data_wb captures 0.
- State machine:
  - IDLE (cnt=0): on an access with MEM_LAT>1, drive stall=1, set cnt=1, go to WAIT.
  - WAIT: stall = (cnt != MEM_LAT-1). cnt increments each cycle while stall is high.
  - In the cycle where stall is low, the access completes: the store is written at that rising edge, or the load data is read asynchronously and captured. cnt returns to 0 and the state returns to IDLE.
  - Completion with MEM_LAT=1: the access completes in its first cycle, stall never rises, and the block stays in IDLE.
- Net timing: an access presented at cycle T stalls cycles T..T+MEM_LAT-2 and completes at the edge ending cycle T+MEM_LAT-1.
- MEM/WB register, every rising edge:
  - If stall=1: load a bubble (wb_wb=0, wr_dst_wb=0, others 0).
  - Otherwise: capture wb, alu_out, wr_dst, and load data (0 for non-loads).
- Upstream inputs must remain stable while stall=1. The block does not re-sample them mid-access.
- Non-memory instructions, including branches, never stall. pc_src and br_addr are valid in the same cycle their inputs are.
- Reset asserted mid-access: the access is abandoned, no write occurs, and the state returns to IDLE with cnt=0.

Optional Feature:
- Macro: MEM_ALIGN_CHK_EN.
- Defined:
  - A load or store with alu_out[1:0] != 0 suppresses the memory write.
  - For such accesses rd_data_wb captures 0, and align_err sets at completion. It stays set until rst.
  - Latency and stall behaviour are unchanged.
- Undefined: alu_out[1:0] is ignored, and align_err is tied to 0.

Test Plan:
- Reset: assert rst mid-cycle with non-zero inputs → all MEM/WB outputs, stall and align_err are 0 immediately, before the next clock edge.
- Store then load, MEM_LAT=2: store rt=0xDEADBEEF to alu_out=0x10 → stall high 1 cycle. Then load from 0x10 → stall high 1 cycle, then rd_data_wb=0xDEADBEEF, wr_dst_wb and wb_wb match inputs, with one bubble (wb_wb=0) before the result.
- MEM_LAT=1, back-to-back: loads from 0x0 and 0x4 → stall never asserts, and results appear on consecutive cycles.
- Branch: mem=3'b100, z_flag=1, br_dst=0x40 → pc_src=1 and br_addr=0x40 in the same cycle. With z_flag=0 → pc_src=0, and no stall in either case.
- Wrap and reset mid-access, ADDR_W=8, MEM_LAT=3: store 0x5 to alu_out=0x400 → word 0 is written. Separately, assert rst in the second stall cycle of a store of 0x7 to 0x8 → a later load of 0x8 returns the old value.
- MEM_ALIGN_CHK_EN defined: store 0x1 to alu_out=0x13 → memory unchanged and align_err=1 after completion; it stays 1 through later aligned accesses until rst.

Source files
------------

// File: rtl/mem_stage.sv
// mem_stage: memory-access stage of a 5-stage MIPS pipeline.
// Resolves branches, performs multi-cycle data-memory loads/stores and
// registers results into the MEM/WB pipeline register.
// Optional feature macro: MEM_ALIGN_CHK_EN (misaligned access detection).
`timescale 1ns/1ps
module mem_stage #(
    parameter int ADDR_W  = 8,
    parameter int MEM_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  wb,
    input  logic [2:0]  mem,
    input  logic [31:0] br_dst,
    input  logic        z_flag,
    input  logic [31:0] alu_out,
    input  logic [31:0] rt,
    input  logic [4:0]  wr_dst,
    output logic        pc_src,
    output logic [31:0] br_addr,
    output logic        stall,
    output logic [1:0]  wb_wb,
    output logic [31:0] rd_data_wb,
    output logic [31:0] alu_out_wb,
    output logic [4:0]  wr_dst_wb,
    output logic        align_err
);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    localparam int         DEPTH    = 2 ** ADDR_W;
    localparam logic [3:0] LAST_CNT = 4'(MEM_LAT - 1);
    localparam bit         MULTI    = (MEM_LAT > 1) ? 1'b1 : 1'b0;

    state_t              state;
    state_t              state_nxt;
    logic [3:0]          cnt;
    logic [3:0]          cnt_nxt;
    logic                stall_core;
    logic                access;
    logic                complete;
    logic                mis;
    logic                wr_en;
    logic [ADDR_W-1:0]   idx;
    logic [31:0]         ld_data;
    logic [31:0]         dmem [DEPTH];

    // Branch resolution is purely combinational and never stalls.
    assign pc_src  = mem[2] & z_flag;
    assign br_addr = br_dst;

    // Word index; upper address bits are dropped so addresses wrap.
    assign idx    = alu_out[ADDR_W+1:2];
    assign access = mem[1] | mem[0];

`ifdef MEM_ALIGN_CHK_EN
    assign mis = (alu_out[1:0] != 2'b00);
`else
    assign mis = 1'b0;
`endif

    // Stall is suppressed while reset is held; completion needs a live access.
    assign stall    = stall_core & ~rst;
    assign complete = ~rst & access & ~stall_core;
    assign wr_en    = complete & mem[0] & ~mis;

    // Load data: only a pure, aligned load returns memory contents.
    assign ld_data = (mem[1] & ~mem[0] & ~mis) ? dmem[idx] : 32'd0;

    // Next-state and stall logic of the access-latency controller.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        stall_core = 1'b0;
        case (state)
            IDLE: begin
                if (access && MULTI) begin
                    stall_core = 1'b1;
                    cnt_nxt    = 4'd1;
                    state_nxt  = WAIT;
                end else begin
                    stall_core = 1'b0;
                    cnt_nxt    = 4'd0;
                    state_nxt  = IDLE;
                end
            end
            WAIT: begin
                if (cnt != LAST_CNT) begin
                    stall_core = 1'b1;
                    cnt_nxt    = cnt + 4'd1;
                    state_nxt  = WAIT;
                end else begin
                    stall_core = 1'b0;
                    cnt_nxt    = 4'd0;
                    state_nxt  = IDLE;
                end
            end
            default: begin
                stall_core = 1'b0;
                cnt_nxt    = 4'd0;
                state_nxt  = IDLE;
            end
        endcase
    end

    // State and latency counter registers; reset abandons any access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Data memory write port; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            dmem[idx] <= rt;
        end
    end

    // MEM/WB pipeline register: bubble while stalled, capture otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_wb      <= 2'd0;
            rd_data_wb <= 32'd0;
            alu_out_wb <= 32'd0;
            wr_dst_wb  <= 5'd0;
        end else if (stall) begin
            wb_wb      <= 2'd0;
            rd_data_wb <= 32'd0;
            alu_out_wb <= 32'd0;
            wr_dst_wb  <= 5'd0;
        end else begin
            wb_wb      <= wb;
            rd_data_wb <= ld_data;
            alu_out_wb <= alu_out;
            wr_dst_wb  <= wr_dst;
        end
    end

    // Sticky misalignment flag, set when a misaligned access completes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            align_err <= 1'b0;
        end else if (complete && mis) begin
            align_err <= 1'b1;
        end else begin
            align_err <= align_err;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: self-checking bench for mem_stage. Three instances run with
// MEM_LAT = 2, 1 and 3; a per-instance word-array model predicts results.
`timescale 1ns/1ps
module tb_mem_stage;

`ifdef MEM_ALIGN_CHK_EN
    localparam bit ALIGN_EN = 1'b1;
`else
    localparam bit ALIGN_EN = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic [1:0]  wb_i      [3];
    logic [2:0]  mem_i     [3];
    logic [31:0] br_dst_i  [3];
    logic        z_i       [3];
    logic [31:0] alu_i     [3];
    logic [31:0] rt_i      [3];
    logic [4:0]  dst_i     [3];
    logic        pc_src_o  [3];
    logic [31:0] br_addr_o [3];
    logic        stall_o   [3];
    logic [1:0]  wb_wb_o   [3];
    logic [31:0] rd_o      [3];
    logic [31:0] alu_wb_o  [3];
    logic [4:0]  dst_wb_o  [3];
    logic        align_o   [3];

    int          lat       [3];
    logic [31:0] mdl       [3][256];
    logic        exp_align [3];
    int          checks;
    int          failures;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        mem_stage #(
            .ADDR_W (8),
            .MEM_LAT((g == 0) ? 2 : ((g == 1) ? 1 : 3))
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .wb        (wb_i[g]),
            .mem       (mem_i[g]),
            .br_dst    (br_dst_i[g]),
            .z_flag    (z_i[g]),
            .alu_out   (alu_i[g]),
            .rt        (rt_i[g]),
            .wr_dst    (dst_i[g]),
            .pc_src    (pc_src_o[g]),
            .br_addr   (br_addr_o[g]),
            .stall     (stall_o[g]),
            .wb_wb     (wb_wb_o[g]),
            .rd_data_wb(rd_o[g]),
            .alu_out_wb(alu_wb_o[g]),
            .wr_dst_wb (dst_wb_o[g]),
            .align_err (align_o[g])
        );
    end

    always #5 clk = ~clk;

    function automatic int widx(input logic [31:0] a);
        return int'((a >> 2) % 256);
    endfunction

    // One instruction on instance k: drive, walk its latency, check every cycle.
    task automatic run_op(input int k, input logic [1:0] wbv, input logic [2:0] mv,
                          input logic [31:0] av, input logic [31:0] rv, input logic [4:0] dv,
                          input logic zf, input logic [31:0] bd);
        int          n;
        logic        acc;
        logic        mis;
        logic [31:0] exp_rd;
        acc = mv[1] | mv[0];
        mis = ALIGN_EN && acc && (av[1:0] != 2'b00);
        n   = acc ? lat[k] : 1;
        exp_rd = (mv[1] && !mv[0] && !mis) ? mdl[k][widx(av)] : 32'd0;
        wb_i[k] = wbv; mem_i[k] = mv; alu_i[k] = av; rt_i[k] = rv;
        dst_i[k] = dv; z_i[k] = zf; br_dst_i[k] = bd;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            checks++;
            if (stall_o[k] !== (i < n - 1)) begin
                failures++;
                $display("FAIL stall k=%0d cyc=%0d got=%b exp=%b", k, i, stall_o[k], (i < n - 1));
            end
            checks++;
            if (pc_src_o[k] !== (mv[2] & zf)) begin
                failures++;
                $display("FAIL pc_src k=%0d got=%b exp=%b", k, pc_src_o[k], mv[2] & zf);
            end
            checks++;
            if (br_addr_o[k] !== bd) begin
                failures++;
                $display("FAIL br_addr k=%0d got=%h exp=%h", k, br_addr_o[k], bd);
            end
            @(posedge clk);
            #1;
            if (i < n - 1) begin
                checks++;
                if (wb_wb_o[k] !== 2'd0 || dst_wb_o[k] !== 5'd0 || alu_wb_o[k] !== 32'd0 || rd_o[k] !== 32'd0) begin
                    failures++;
                    $display("FAIL bubble k=%0d got wb=%b dst=%0d alu=%h rd=%h exp all 0",
                             k, wb_wb_o[k], dst_wb_o[k], alu_wb_o[k], rd_o[k]);
                end
            end
        end
        if (mv[0] && !mis) mdl[k][widx(av)] = rv;
        if (mis) exp_align[k] = 1'b1;
        checks++;
        if (wb_wb_o[k] !== wbv || dst_wb_o[k] !== dv || alu_wb_o[k] !== av) begin
            failures++;
            $display("FAIL memwb k=%0d got wb=%b dst=%0d alu=%h exp wb=%b dst=%0d alu=%h",
                     k, wb_wb_o[k], dst_wb_o[k], alu_wb_o[k], wbv, dv, av);
        end
        checks++;
        if (rd_o[k] !== exp_rd) begin
            failures++;
            $display("FAIL rd_data k=%0d addr=%h got=%h exp=%h", k, av, rd_o[k], exp_rd);
        end
        checks++;
        if (align_o[k] !== exp_align[k]) begin
            failures++;
            $display("FAIL align_err k=%0d got=%b exp=%b", k, align_o[k], exp_align[k]);
        end
        mem_i[k] = 3'b000;
    endtask

    task automatic check_all_zero(input string tag);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (stall_o[k] !== 1'b0 || wb_wb_o[k] !== 2'd0 || rd_o[k] !== 32'd0 ||
                alu_wb_o[k] !== 32'd0 || dst_wb_o[k] !== 5'd0 || align_o[k] !== 1'b0) begin
                failures++;
                $display("FAIL %s k=%0d got stall=%b wb=%b rd=%h alu=%h dst=%0d align=%b exp all 0",
                         tag, k, stall_o[k], wb_wb_o[k], rd_o[k], alu_wb_o[k], dst_wb_o[k], align_o[k]);
            end
        end
    endtask

    task automatic test_reset();
        #12;
        check_all_zero("reset_state");
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_store_load();
        run_op(0, 2'b00, 3'b001, 32'h0000_0010, 32'hDEADBEEF, 5'd0, 1'b0, 32'd0);
        run_op(0, 2'b11, 3'b010, 32'h0000_0010, 32'h0, 5'd9, 1'b0, 32'd0);
        run_op(0, 2'b10, 3'b011, 32'h0000_0020, 32'h1234_5678, 5'd3, 1'b0, 32'd0);
        run_op(0, 2'b11, 3'b010, 32'h0000_0020, 32'h0, 5'd4, 1'b0, 32'd0);
    endtask

    task automatic test_back_to_back();
        run_op(1, 2'b00, 3'b001, 32'h0, 32'hA5A5_0001, 5'd0, 1'b0, 32'd0);
        run_op(1, 2'b00, 3'b001, 32'h4, 32'h5A5A_0002, 5'd0, 1'b0, 32'd0);
        run_op(1, 2'b11, 3'b010, 32'h0, 32'h0, 5'd1, 1'b0, 32'd0);
        run_op(1, 2'b01, 3'b010, 32'h4, 32'h0, 5'd2, 1'b0, 32'd0);
    endtask

    task automatic test_branch();
        run_op(0, 2'b00, 3'b100, 32'h0, 32'h0, 5'd0, 1'b1, 32'h0000_0040);
        run_op(0, 2'b00, 3'b100, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0000_0040);
        run_op(2, 2'b00, 3'b100, 32'h0, 32'h0, 5'd0, 1'b1, 32'h0000_1234);
    endtask

    task automatic test_wrap_and_reset_mid_access();
        run_op(2, 2'b00, 3'b001, 32'h0000_0400, 32'h5, 5'd0, 1'b0, 32'd0);
        run_op(2, 2'b11, 3'b010, 32'h0000_0000, 32'h0, 5'd7, 1'b0, 32'd0);
        run_op(2, 2'b00, 3'b001, 32'h0000_0008, 32'h33, 5'd0, 1'b0, 32'd0);
        wb_i[2] = 2'b00; mem_i[2] = 3'b001; alu_i[2] = 32'h8; rt_i[2] = 32'h7;
        @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if (stall_o[2] !== 1'b1) begin
            failures++;
            $display("FAIL mid_stall got=%b exp=1", stall_o[2]);
        end
        #1 rst = 1'b1;
        #1 check_all_zero("reset_mid_access");
        mem_i[2] = 3'b000;
        for (int k = 0; k < 3; k++) exp_align[k] = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        run_op(2, 2'b11, 3'b010, 32'h0000_0008, 32'h0, 5'd8, 1'b0, 32'd0);
    endtask

    task automatic test_align();
        run_op(0, 2'b00, 3'b001, 32'h0000_0013, 32'h1, 5'd0, 1'b0, 32'd0);
        run_op(0, 2'b11, 3'b010, 32'h0000_0010, 32'h0, 5'd5, 1'b0, 32'd0);
        run_op(0, 2'b00, 3'b001, 32'h0000_0030, 32'h77, 5'd0, 1'b0, 32'd0);
        run_op(0, 2'b11, 3'b010, 32'h0000_0031, 32'h0, 5'd6, 1'b0, 32'd0);
    endtask

    task automatic test_random();
        logic [2:0]  mv;
        logic [31:0] av;
        for (int k = 0; k < 3; k++) begin
            for (int j = 0; j < 25; j++) begin
                case ($urandom_range(0, 4))
                    0: mv = 3'b000;
                    1: mv = 3'b001;
                    2: mv = 3'b010;
                    3: mv = 3'b011;
                    default: mv = 3'b100;
                endcase
                av = ($urandom & 32'hFFFF_FC00) | (32'($urandom_range(0, 15)) << 2);
                if ($urandom_range(0, 4) == 0) av = av | 32'($urandom_range(1, 3));
                run_op(k, 2'($urandom_range(0, 3)), mv, av, $urandom, 5'($urandom_range(0, 31)),
                       1'($urandom_range(0, 1)), $urandom);
            end
        end
    endtask

    task automatic test_reset_async();
        wb_i[0] = 2'b11; mem_i[0] = 3'b010; alu_i[0] = 32'h10; dst_i[0] = 5'd12;
        wb_i[2] = 2'b11; mem_i[2] = 3'b001; alu_i[2] = 32'h44; rt_i[2] = 32'h99;
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check_all_zero("reset_async");
        for (int k = 0; k < 3; k++) mem_i[k] = 3'b000;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        clk = 1'b0;
        rst = 1'b1;
        checks = 0;
        failures = 0;
        lat[0] = 2; lat[1] = 1; lat[2] = 3;
        for (int k = 0; k < 3; k++) begin
            wb_i[k] = 2'd0; mem_i[k] = 3'd0; br_dst_i[k] = 32'd0; z_i[k] = 1'b0;
            alu_i[k] = 32'd0; rt_i[k] = 32'd0; dst_i[k] = 5'd0; exp_align[k] = 1'b0;
            for (int a = 0; a < 256; a++) mdl[k][a] = 32'd0;
        end
        test_reset();
        test_store_load();
        test_back_to_back();
        test_branch();
        test_wrap_and_reset_mid_access();
        test_align();
        test_random();
        test_reset_async();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
